// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               neg;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     madd;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_result;

    logic               in_sa;
    logic               in_sb;
    logic               in_na;
    logic               in_nb;
    logic [WIDTH-1:0]   in_ma;
    logic [WIDTH-1:0]   in_mb;
    logic               fast;
    logic [WIDTH-1:0]   fast_result;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    // One iteration of the datapath and the final sign fix-up
    always_comb begin
        madd    = {1'b0, hi} + {1'b0, mag_a};
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, mag_b};
        acc_nxt = acc;
        if (op[2]) begin
            if (diff[WIDTH])
                acc_nxt = {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            else
                acc_nxt = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        end else begin
            if (lo[0])
                acc_nxt = {madd, lo[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, hi, lo[WIDTH-1:1]};
        end
        prod = neg ? -acc_nxt : acc_nxt;
        fix_result = '0;
        case (op)
            3'b000:  fix_result = prod[WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  fix_result = prod[2*WIDTH-1:WIDTH];
            3'b100,
            3'b101:  fix_result = neg ? -acc_nxt[WIDTH-1:0]
                                      : acc_nxt[WIDTH-1:0];
            default: fix_result = sign_a ? -acc_nxt[2*WIDTH-1:WIDTH]
                                         : acc_nxt[2*WIDTH-1:WIDTH];
        endcase
    end

    // Operand decode at accept: signedness, magnitudes and fast paths
    always_comb begin
        in_sa = (req_op == 3'b000) || (req_op == 3'b001) ||
                (req_op == 3'b010) || (req_op == 3'b100) ||
                (req_op == 3'b110);
        in_sb = (req_op == 3'b000) || (req_op == 3'b001) ||
                (req_op == 3'b100) || (req_op == 3'b110);
        in_na = in_sa & req_a[WIDTH-1];
        in_nb = in_sb & req_b[WIDTH-1];
        in_ma = in_na ? -req_a : req_a;
        in_mb = in_nb ? -req_b : req_b;
        fast = 1'b0;
        fast_result = '0;
        if (req_op[2] && req_b == '0) begin
            fast = 1'b1;
            fast_result = req_op[1] ? req_a : ONES;
        end else if (req_op[2] && !req_op[0] &&
                     req_a == MSB && req_b == ONES) begin
            fast = 1'b1;
            fast_result = req_op[1] ? '0 : MSB;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            op          <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            sign_a      <= 1'b0;
            neg         <= 1'b0;
            acc         <= '0;
            resp_result <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op     <= req_op;
                        mag_a  <= in_ma;
                        mag_b  <= in_mb;
                        sign_a <= in_na;
                        neg    <= in_na ^ in_nb;
                        acc    <= req_op[2] ? {{WIDTH{1'b0}}, in_ma}
                                            : {{WIDTH{1'b0}}, in_mb};
                        if (fast) begin
                            resp_result <= fast_result;
                            state       <= DONE;
                        end else begin
                            count <= CW'(WIDTH);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        resp_result <= fix_result;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv.
// Hand-computed RV32M results, latency, backpressure, flush and reset.
module tb_ex_muldiv;
    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from accept edge to resp_valid
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_op = ~op;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_idle_rdy"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, resp_result, exp);
        retire(tag);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0;
        req_b = '0; flush = 1'b0; resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
        run("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 32);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32);
        run("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32);
        run("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 32);
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 32);

        run("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run("rem_z",  3'b110, 32'd5, 32'd0, 32'd5, 0);
        run("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 0);
        run("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // Backpressure: response must hold for 10 cycles
        issue(3'b000, 32'd12345, 32'd1000, lat);
        chk("bp_lat", lat, 32);
        held = 32'd12345000;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid && !req_ready && resp_result == held)
                seen++;
        end
        chk("bp_stable", seen, 10);
        chk("bp_result", resp_result, held);
        retire("bp");
        run("bp_next", 3'b101, 32'd1000, 32'd10, 32'd100, 32);

        // Flush a divide at N+10
        @(negedge clk);
        req_op = 3'b100; req_a = 32'd99; req_b = 32'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {31'd0, req_ready}, 32'd1);
        chk("flush_vld", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("flush_noresp", seen, 0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        req_op = 3'b000; req_a = 32'd3; req_b = 32'd3;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_block", {31'd0, req_ready}, 32'd1);

        // Async reset mid-BUSY
        issue(3'b101, 32'd50, 32'd0, lat);
        retire("pre_rst");
        @(negedge clk);
        req_op = 3'b011; req_a = 32'hFFFF_FFFF; req_b = 32'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rdy", {31'd0, req_ready}, 32'd1);
        chk("arst_vld", {31'd0, resp_valid}, 32'd0);
        chk("arst_res", resp_result, 32'd0);
        #1 rst = 1'b0;
        run("post_rst", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the single-cycle integer ALU and branch comparator.
- The pipeline issues a request with a valid/ready handshake. The unit responds a fixed number of cycles later through a valid/ready response port.
- EX stalls on the response.
- Covers all eight RV32M operations, selected by funct3.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the iteration counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a  input  WIDTH  rs1 operand
- req_b  input  WIDTH  rs2 operand
- flush  input  1  abort any in-flight operation (branch mispredict / exception)
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_result  output  WIDTH  result; meaningful only while resp_valid=1

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset value, entered asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, internal counters/registers=0.
- Reset asserted mid-operation discards the operation; no response is produced.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid=1 at the edge.
  - The unit latches op, operand magnitudes and sign flags.
  - The unit then goes to BUSY with count=WIDTH, or directly to DONE on a fast path.
- Fast paths, accepted at edge N, resp_valid high in cycle N+1:
  - DIV/DIVU with b=0: quotient=32'hFFFF_FFFF.
  - REM/REMU with b=0: result=a.
  - DIV with a=32'h8000_0000, b=32'hFFFF_FFFF: result=32'h8000_0000.
  - REM with the same operands: result=0.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Unsigned ops: neither operand signed.
  - Signed operands are converted to magnitude at accept time.
- Multiply:
  - Radix-2 shift-add on magnitudes, one bit per cycle, into a 64-bit accumulator.
  - Final product is negated if sign_a^sign_b (signed operands only).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Radix-2 restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is negated if sign_a^sign_b; remainder takes the sign of a (signed ops only).
- BUSY:
  - Decrements count each edge.
  - When count reaches 0, the sign fix-up is applied and the result is registered into resp_result on the same edge as the DONE transition.
  - Normal latency: accept at edge N, resp_valid high from cycle N+WIDTH+1 (N+33).
- DONE:
  - resp_valid=1; resp_result is held stable until handshake.
  - When resp_ready=1 at the edge, the unit returns to IDLE and resp_valid drops.
  - There is no back-to-back accept in the same cycle as the response handshake; req_ready stays 0 in DONE.
  - resp_valid with resp_ready=0 holds indefinitely with no change in output.
- flush:
  - Flush in BUSY or DONE returns the unit to IDLE on the next edge; resp_valid=0 from the next cycle.
  - Flush in IDLE blocks acceptance that cycle, even if req_valid=1.
  - Flush has priority over the resp handshake and over count expiry.
- req_op, req_a and req_b are don't-care outside the accept cycle; changes during BUSY must not affect the result.
- All arithmetic wraps modulo 2^32 as RV32M specifies; no exceptions are raised.

Test Plan:
- MUL a=7, b=-3 (32'hFFFF_FFFD) -> resp_valid at cycle N+33, result=32'hFFFF_FFEB. MULH with the same operands -> 32'hFFFF_FFFF. MULHU -> 32'h0000_0006.
- MULHSU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> 32'hFFFF_FFFF. MULH a=b=32'h8000_0000 -> 32'h4000_0000.
- DIV a=-7, b=2 -> 32'hFFFF_FFFD. REM a=-7, b=2 -> 32'hFFFF_FFFF. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. Each at N+33.
- Fast paths:
  - DIVU a=5, b=0 -> 32'hFFFF_FFFF at N+1.
  - REM a=5, b=0 -> 5.
  - DIV a=32'h8000_0000, b=-1 -> 32'h8000_0000 at N+1.
  - REM with the same operands -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid rises -> result and resp_valid stable, req_ready=0. Raise resp_ready -> IDLE next cycle, then accept a new request.
- Abort:
  - flush at N+10 of a DIV -> IDLE at N+11; no resp_valid ever appears for that request.
  - Async rst pulse mid-BUSY -> outputs at reset values immediately, before the next clock edge.
  - Next request then completes normally.
